// File: rtl/miriscv_sw_pkg.sv
// Shared definitions for the switch peripheral: bus widths, register map,
// status/control bit positions and the interrupt FSM state encoding.
package miriscv_sw_pkg;

  localparam int unsigned SW_ADDR_W = 8;
  localparam int unsigned SW_DATA_W = 32;

  // Byte offsets of the word registers; address bits [1:0] are ignored.
  localparam logic [SW_ADDR_W-1:0] SW_VAL_ADDR    = 8'h00;
  localparam logic [SW_ADDR_W-1:0] SW_CTRL_ADDR   = 8'h04;
  localparam logic [SW_ADDR_W-1:0] SW_STATUS_ADDR = 8'h08;

  localparam int unsigned CTRL_IRQ_EN_BIT    = 0;
  localparam int unsigned STATUS_PENDING_BIT = 0;
  localparam int unsigned STATUS_OVERRUN_BIT = 1;

  typedef enum logic [1:0] {
    SW_IRQ_IDLE    = 2'd0,
    SW_IRQ_PENDING = 2'd1,
    SW_IRQ_DONE    = 2'd2
  } sw_irq_state_e;

  // Word-granular address match.
  function automatic logic sw_addr_hit(input logic [SW_ADDR_W-1:0] addr,
                                       input logic [SW_ADDR_W-1:0] reg_addr);
    return addr[SW_ADDR_W-1:2] == reg_addr[SW_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/miriscv_sw_ctrl_if.sv
// Data-bus and interrupt-handshake bundle between the core (master) and the
// switch peripheral (slave).
//   req_i/we_i/addr_i/wdata_i : single-cycle access strobe and write payload
//   rdata_o                   : registered read data
//   int_req_o/int_fin_i       : level interrupt request / completion pulse
interface miriscv_sw_ctrl_if;
  import miriscv_sw_pkg::*;

  logic                 req_i;
  logic                 we_i;
  logic [SW_ADDR_W-1:0] addr_i;
  logic [SW_DATA_W-1:0] wdata_i;
  logic [SW_DATA_W-1:0] rdata_o;
  logic                 int_req_o;
  logic                 int_fin_i;

  modport master (
    output req_i, we_i, addr_i, wdata_i, int_fin_i,
    input  rdata_o, int_req_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, int_fin_i,
    output rdata_o, int_req_o
  );

endinterface

// File: rtl/miriscv_sw_ctrl_debounce.sv
// Switch input conditioning: 2-flop synchronizer followed by a stability
// counter. A new value is committed to sw_val after DEBOUNCE_CYCLES
// consecutive cycles of an unchanged synchronized value that differs from
// the committed one.
//   clk_i, rst_i : clock, async active-high reset
//   sw_i         : raw switches (asynchronous)
//   sw_val       : committed switch value (registered)
//   change       : high in the cycle whose edge commits a new sw_val
module miriscv_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SW_W            = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] sw_val,
  output logic            change
);

  localparam int unsigned CNT_W = 8;

  logic [SW_W-1:0]  sync_q1;
  logic [SW_W-1:0]  sw_sync;
  logic [SW_W-1:0]  sw_prev;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             restart;

  // Any movement, or agreement with the committed value, restarts the count.
  assign restart = (sw_sync != sw_prev) || (sw_sync == sw_val);
  assign cnt_inc = stable_cnt + CNT_W'(1);
  // Combinational so the interrupt FSM reacts at the same edge sw_val commits.
  assign change  = !restart && (cnt_inc == CNT_W'(DEBOUNCE_CYCLES));

  // Synchronizer, history and stability counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q1    <= '0;
      sw_sync    <= '0;
      sw_prev    <= '0;
      stable_cnt <= '0;
      sw_val     <= '0;
    end else begin
      sync_q1 <= sw_i;
      sw_sync <= sync_q1;
      sw_prev <= sw_sync;
      if (restart || change) begin
        stable_cnt <= '0;
      end else begin
        stable_cnt <= cnt_inc;
      end
      if (change) begin
        sw_val <= sw_sync;
      end
    end
  end

endmodule

// File: rtl/miriscv_sw_ctrl.sv
// Memory-mapped switch peripheral: debounced switch value, control/status
// registers and the responder side of the core interrupt handshake.
//   clk_i, rst_i : clock, async active-high reset
//   sw_i         : raw board switches
//   bus          : slave side of miriscv_sw_ctrl_if (register access + irq)
module miriscv_sw_ctrl
  import miriscv_sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SW_W            = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SW_W-1:0]    sw_i,
  miriscv_sw_ctrl_if.slave   bus
);

  logic [SW_W-1:0]      sw_val;
  logic                 change;
  logic                 irq_en;
  logic                 overrun;
  logic                 dirty;
  sw_irq_state_e        state;

  logic                 wr_c;
  logic                 rd_c;
  logic                 sel_val_c;
  logic                 sel_ctrl_c;
  logic                 sel_status_c;
  logic                 ovr_clr_c;
  logic                 pending_c;
  logic [SW_DATA_W-1:0] rdata_c;
  logic                 unused_bits;

  miriscv_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SW_W            (SW_W)
  ) u_debounce (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sw_i   (sw_i),
    .sw_val (sw_val),
    .change (change)
  );

  assign wr_c         = bus.req_i &  bus.we_i;
  assign rd_c         = bus.req_i & ~bus.we_i;
  assign sel_val_c    = sw_addr_hit(bus.addr_i, SW_VAL_ADDR);
  assign sel_ctrl_c   = sw_addr_hit(bus.addr_i, SW_CTRL_ADDR);
  assign sel_status_c = sw_addr_hit(bus.addr_i, SW_STATUS_ADDR);
  assign ovr_clr_c    = wr_c & sel_status_c & bus.wdata_i[STATUS_OVERRUN_BIT];
  assign pending_c    = (state == SW_IRQ_PENDING);
  assign unused_bits  = ^{bus.addr_i[1:0], bus.wdata_i[SW_DATA_W-1:2]};

  // Read data mux; unmapped addresses return zero.
  always_comb begin
    rdata_c = '0;
    if (sel_val_c) begin
      rdata_c = SW_DATA_W'(sw_val);
    end else if (sel_ctrl_c) begin
      rdata_c[CTRL_IRQ_EN_BIT] = irq_en;
    end else if (sel_status_c) begin
      rdata_c[STATUS_PENDING_BIT] = pending_c;
      rdata_c[STATUS_OVERRUN_BIT] = overrun;
    end
  end

  // Control register and registered read port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en      <= 1'b0;
      bus.rdata_o <= '0;
    end else begin
      if (wr_c && sel_ctrl_c) begin
        irq_en <= bus.wdata_i[CTRL_IRQ_EN_BIT];
      end
      if (rd_c) begin
        bus.rdata_o <= rdata_c;
      end
    end
  end

  // Interrupt handshake FSM; overrun clear is placed first so a set wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= SW_IRQ_IDLE;
      bus.int_req_o <= 1'b0;
      overrun       <= 1'b0;
      dirty         <= 1'b0;
    end else begin
      if (ovr_clr_c) begin
        overrun <= 1'b0;
      end
      case (state)
        SW_IRQ_IDLE: begin
          if (change && irq_en) begin
            state         <= SW_IRQ_PENDING;
            bus.int_req_o <= 1'b1;
          end
        end
        SW_IRQ_PENDING: begin
          if (change) begin
            overrun <= 1'b1;
            dirty   <= 1'b1;
          end
          if (bus.int_fin_i) begin
            state         <= SW_IRQ_DONE;
            bus.int_req_o <= 1'b0;
          end
        end
        SW_IRQ_DONE: begin
          // A change landing during the gap cycle counts as unserviced too.
          dirty <= 1'b0;
          if ((dirty || change) && irq_en) begin
            state         <= SW_IRQ_PENDING;
            bus.int_req_o <= 1'b1;
          end else begin
            state <= SW_IRQ_IDLE;
          end
        end
        default: begin
          state         <= SW_IRQ_IDLE;
          bus.int_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_sw_ctrl.sv
// Directed self-checking bench for miriscv_sw_ctrl (DEBOUNCE_CYCLES = 4).
module tb_miriscv_sw_ctrl;
  import miriscv_sw_pkg::*;

  localparam int unsigned D    = 4;
  localparam int unsigned SW_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [SW_W-1:0] sw;
  int              n_chk  = 0;
  int              n_fail = 0;
  int              n_rise = 0;
  int              rise_base;
  logic [31:0]     rd;

  miriscv_sw_ctrl_if bus ();

  miriscv_sw_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .SW_W            (SW_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sw_i  (sw),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge bus.int_req_o) n_rise++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = a;
    bus.wdata_i = d;
    cyc();
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = a;
    cyc();
    bus.req_i  = 1'b0;
    d = bus.rdata_o;
  endtask

  task automatic fin_pulse();
    bus.int_fin_i = 1'b1;
    cyc();
    bus.int_fin_i = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    sw            = 16'h1111;
    bus.req_i     = 1'b0;
    bus.we_i      = 1'b0;
    bus.addr_i    = '0;
    bus.wdata_i   = '0;
    bus.int_fin_i = 1'b0;

    // Reset and enable
    repeat (3) cyc();
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_int_req", 32'(bus.int_req_o), 32'h0);
    rst = 1'b0;
    bus_write(SW_CTRL_ADDR, 32'h1);
    repeat (D + 1) cyc();
    check("en_req_before_commit", 32'(bus.int_req_o), 32'h0);
    cyc();
    check("en_req_at_commit", 32'(bus.int_req_o), 32'h1);
    bus_read(SW_VAL_ADDR, rd);
    check("en_sw_val", rd, 32'h0000_1111);
    fin_pulse();
    check("en_req_after_fin", 32'(bus.int_req_o), 32'h0);
    repeat (3) cyc();
    check("en_single_pulse", 32'(n_rise), 32'd1);

    // Change and completion with exact latency
    sw = 16'h1110;
    repeat (D + 2) cyc();
    check("chg_req_early", 32'(bus.int_req_o), 32'h0);
    cyc();
    check("chg_req_rise", 32'(bus.int_req_o), 32'h1);
    bus_read(SW_STATUS_ADDR, rd);
    check("chg_status_pending", rd, 32'h1);
    bus_read(SW_VAL_ADDR, rd);
    check("chg_sw_val", rd, 32'h0000_1110);
    fin_pulse();
    check("chg_req_fall", 32'(bus.int_req_o), 32'h0);
    repeat (2) cyc();
    bus_read(SW_STATUS_ADDR, rd);
    check("chg_status_idle", rd, 32'h0);
    check("chg_req_stays_low", 32'(bus.int_req_o), 32'h0);

    // Restore 16'h1111 and service its interrupt
    sw = 16'h1111;
    repeat (D + 3) cyc();
    check("restore_req", 32'(bus.int_req_o), 32'h1);
    fin_pulse();
    repeat (2) cyc();

    // Glitch rejection: sub-period pulse, then one held D-1 cycles
    rise_base = n_rise;
    #3 sw = 16'h1011;
    #2 sw = 16'h1111;
    repeat (10) cyc();
    check("glitch_short_no_req", 32'(n_rise - rise_base), 32'd0);
    bus_read(SW_VAL_ADDR, rd);
    check("glitch_short_sw_val", rd, 32'h0000_1111);
    sw = 16'h1011;
    repeat (D - 1) cyc();
    sw = 16'h1111;
    repeat (10) cyc();
    check("glitch_long_no_req", 32'(n_rise - rise_base), 32'd0);
    check("glitch_long_req_low", 32'(bus.int_req_o), 32'h0);
    bus_read(SW_VAL_ADDR, rd);
    check("glitch_long_sw_val", rd, 32'h0000_1111);

    // Overrun: two commits without completion
    sw = 16'h0001;
    repeat (D + 3) cyc();
    check("ovr_first_req", 32'(bus.int_req_o), 32'h1);
    sw = 16'h0000;
    repeat (D + 3) cyc();
    bus_read(SW_STATUS_ADDR, rd);
    check("ovr_status", rd, 32'h3);
    bus_read(SW_VAL_ADDR, rd);
    check("ovr_sw_val", rd, 32'h0);
    fin_pulse();
    check("ovr_gap_low", 32'(bus.int_req_o), 32'h0);
    cyc();
    check("ovr_reraise", 32'(bus.int_req_o), 32'h1);
    bus_read(SW_STATUS_ADDR, rd);
    check("ovr_status_reraised", rd, 32'h3);
    bus_write(SW_STATUS_ADDR, 32'h2);
    bus_read(SW_STATUS_ADDR, rd);
    check("ovr_w1c", rd, 32'h1);
    repeat (3) cyc();
    check("rdata_held", bus.rdata_o, 32'h1);
    fin_pulse();
    cyc();
    bus_read(SW_STATUS_ADDR, rd);
    check("ovr_final_status", rd, 32'h0);
    check("ovr_final_req", 32'(bus.int_req_o), 32'h0);

    // Interrupts disabled, control bits and address decode
    bus_write(SW_CTRL_ADDR, 32'hFFFF_FFFE);
    bus_read(SW_CTRL_ADDR, rd);
    check("ctrl_only_bit0", rd, 32'h0);
    rise_base = n_rise;
    sw = 16'h00F0;
    repeat (D + 3) cyc();
    bus_read(SW_VAL_ADDR, rd);
    check("dis_sw_val", rd, 32'h0000_00F0);
    check("dis_req_low", 32'(bus.int_req_o), 32'h0);
    fin_pulse();
    cyc();
    check("dis_fin_ignored", 32'(bus.int_req_o), 32'h0);
    bus_read(SW_STATUS_ADDR, rd);
    check("dis_status", rd, 32'h0);
    check("dis_no_rise", 32'(n_rise - rise_base), 32'd0);
    bus_write(8'h0C, 32'hFFFF_FFFF);
    bus_read(8'h0C, rd);
    check("unmapped_read", rd, 32'h0);
    bus_read(SW_CTRL_ADDR, rd);
    check("unmapped_write_ignored", rd, 32'h0);
    bus_read(8'h02, rd);
    check("addr_low_bits_ignored", rd, 32'h0000_00F0);

    // Reset in the middle of a request
    bus_write(SW_CTRL_ADDR, 32'h1);
    sw = 16'h0F0F;
    repeat (D + 3) cyc();
    check("mid_req_high", 32'(bus.int_req_o), 32'h1);
    #2;
    rst = 1'b1;
    sw  = 16'h0000;
    #1;
    check("mid_req_async_drop", 32'(bus.int_req_o), 32'h0);
    check("mid_rdata_reset", bus.rdata_o, 32'h0);
    repeat (2) cyc();
    rst = 1'b0;
    bus_read(SW_VAL_ADDR, rd);
    check("post_rst_sw_val", rd, 32'h0);
    bus_read(SW_CTRL_ADDR, rd);
    check("post_rst_ctrl", rd, 32'h0);
    bus_read(SW_STATUS_ADDR, rd);
    check("post_rst_status", rd, 32'h0);
    repeat (D + 3) cyc();
    check("post_rst_req", 32'(bus.int_req_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
